// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data_mem arbiter: FSM state codes, port ids and
// the wait-counter width helper.
package dmem_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t DRAIN = 3'd0;
    localparam state_t IDLE  = 3'd1;
    localparam state_t ISSUE = 3'd2;
    localparam state_t WAIT  = 3'd3;
    localparam state_t RESP  = 3'd4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES_DEF + 1);

    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way request picker: fixed priority to port 0 or
// round-robin away from the last granted port.
import dmem_arb_pkg::*;

module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    input  logic fixed_prio,
    output logic grant_id,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = fixed_prio ? PORT_CPU : ~rr_last;
        end else begin
            grant_id = req1 ? PORT_AUX : PORT_CPU;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of data_mem: one outstanding access, single-cycle
// read/write strobes, busy-window tracking, timeout abort and post-reset drain.
import dmem_arb_pkg::*;

module data_mem_arbiter #(
    parameter bit FIXED_PRIO     = 1'b0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [3:0]  sign_mask0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [3:0]  sign_mask1,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall
);

    localparam int CNT_W = wait_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic              rr_last;
    logic              winner;
    logic              lat_we;
    logic              seen_busy;
    logic              timed_out;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant_id;
    logic              grant_valid;
    logic              done_ok;
    logic              done_to;
    logic              issue_d;
    logic              resp_d;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_mask;
    logic [31:0]       resp_rdata;

    dmem_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .rr_last     (rr_last),
        .fixed_prio  (FIXED_PRIO),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DRAIN;
        end else begin
            state <= state_n;
        end
    end

    // Completion needs a busy cycle first: data_mem raises clk_stall only after sampling the strobe.
    always_comb begin
        done_ok = (state == WAIT) && !mem_stall && seen_busy;
        done_to = (state == WAIT) && !done_ok && (wait_cnt == CNT_LAST);
        state_n = state;
        case (state)
            DRAIN:   if (!mem_stall) state_n = IDLE;
            IDLE:    if (grant_valid) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (done_ok || done_to) state_n = RESP;
            RESP:    state_n = timed_out ? DRAIN : IDLE;
            default: state_n = DRAIN;
        endcase
    end

    always_comb begin
        issue_d    = (state_n == ISSUE);
        resp_d     = (state_n == RESP);
        sel_we     = (grant_id == PORT_AUX) ? we1        : we0;
        sel_addr   = (grant_id == PORT_AUX) ? addr1      : addr0;
        sel_wdata  = (grant_id == PORT_AUX) ? wdata1     : wdata0;
        sel_mask   = (grant_id == PORT_AUX) ? sign_mask1 : sign_mask0;
        resp_rdata = (lat_we || done_to) ? 32'h0 : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rdata0        <= 32'h0;
            rdata1        <= 32'h0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_sign_mask <= 4'h0;
            rr_last       <= PORT_AUX;
            winner        <= PORT_CPU;
            lat_we        <= 1'b0;
            seen_busy     <= 1'b0;
            timed_out     <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            mem_memread  <= issue_d & ~sel_we;
            mem_memwrite <= issue_d & sel_we;
            ack0         <= resp_d & (winner == PORT_CPU);
            ack1         <= resp_d & (winner == PORT_AUX);
            err0         <= resp_d & (winner == PORT_CPU) & done_to;
            err1         <= resp_d & (winner == PORT_AUX) & done_to;
            if (issue_d) begin
                winner        <= grant_id;
                rr_last       <= grant_id;
                lat_we        <= sel_we;
                mem_addr      <= sel_addr;
                mem_wdata     <= sel_wdata;
                mem_sign_mask <= sel_mask;
                seen_busy     <= 1'b0;
                wait_cnt      <= '0;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
                if (mem_stall) seen_busy <= 1'b1;
            end
            if (resp_d) begin
                timed_out <= done_to;
                if (winner == PORT_AUX) rdata1 <= resp_rdata;
                else                    rdata0 <= resp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two DUTs (round-robin and fixed priority), each
// in front of a behavioural data_mem with a configurable busy window.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [1:0]  rst_n, req0, req1, we0, we1;
    logic [31:0] addr0 [2];
    logic [31:0] addr1 [2];
    logic [31:0] wdata0 [2];
    logic [31:0] wdata1 [2];
    logic [3:0]  sm0 [2];
    logic [3:0]  sm1 [2];
    logic [1:0]  ack0, ack1, err0, err1, mem_memread, mem_memwrite, stall_v;
    logic [31:0] rdata0 [2];
    logic [31:0] rdata1 [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_sm [2];
    int          lat [2];
    logic [1:0]  force_stall;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (m[2])      r = wd;
        else if (m[1]) r[a[1]*16 +: 16] = wd[15:0];
        else           r[a*8 +: 8] = wd[7:0];
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [3:0] m,
                                            input logic [1:0] a);
        if (m[2])      return w;
        else if (m[1]) return {16'h0, w[a[1]*16 +: 16]};
        else           return {24'h0, w[a*8 +: 8]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        logic [31:0] mem [0:2047];
        logic [31:0] rd = 32'h0;
        int          busy = 0;
        logic        init_done = 1'b0;
        logic [10:0] widx;
        assign widx       = mem_addr[g][12:2];
        assign stall_v[g] = force_stall[g] | (busy != 0);

        always @(posedge clk) begin
            if (!init_done) begin
                for (int k = 0; k < 2048; k++) mem[k] <= 32'h0;
                mem[11'h400] <= 32'h11223344;
                mem[11'h401] <= 32'hDEADBEEF;
                init_done <= 1'b1;
            end else if (busy != 0) begin
                busy <= busy - 1;
            end else if (mem_memread[g] | mem_memwrite[g]) begin
                busy <= lat[g];
                if (mem_memwrite[g]) mem[widx] <= merge(mem[widx], mem_wdata[g], mem_sm[g], mem_addr[g][1:0]);
                else                 rd <= extract(mem[widx], mem_sm[g], mem_addr[g][1:0]);
            end
        end

        data_mem_arbiter #(
            .FIXED_PRIO     (g == 1 ? 1'b1 : 1'b0),
            .TIMEOUT_CYCLES (16)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .req0          (req0[g]),
            .we0           (we0[g]),
            .addr0         (addr0[g]),
            .wdata0        (wdata0[g]),
            .sign_mask0    (sm0[g]),
            .req1          (req1[g]),
            .we1           (we1[g]),
            .addr1         (addr1[g]),
            .wdata1        (wdata1[g]),
            .sign_mask1    (sm1[g]),
            .ack0          (ack0[g]),
            .rdata0        (rdata0[g]),
            .err0          (err0[g]),
            .ack1          (ack1[g]),
            .rdata1        (rdata1[g]),
            .err1          (err1[g]),
            .mem_addr      (mem_addr[g]),
            .mem_wdata     (mem_wdata[g]),
            .mem_memwrite  (mem_memwrite[g]),
            .mem_memread   (mem_memread[g]),
            .mem_sign_mask (mem_sm[g]),
            .mem_rdata     (rd),
            .mem_stall     (stall_v[g])
        );
    end

    // Protocol monitor: strobe/ack shape and grant order per instance.
    int          strobe_viol = 0;
    int          ack_viol = 0;
    int          strobe_seen = 0;
    logic [1:0]  prev_strobe = 2'b00;
    logic [1:0]  prev_ack = 2'b00;
    logic [31:0] iss_addr [2];
    logic [3:0]  iss_sm [2];
    logic        iss_we [2];
    int          glog0[$];
    int          glog1[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i]) begin
                if (mem_memread[i] | mem_memwrite[i]) begin
                    strobe_seen++;
                    if (prev_strobe[i] || (mem_memread[i] & mem_memwrite[i])) strobe_viol++;
                    iss_addr[i] = mem_addr[i];
                    iss_sm[i]   = mem_sm[i];
                    iss_we[i]   = mem_memwrite[i];
                end
                if ((ack0[i] & ack1[i]) || ((ack0[i] | ack1[i]) & prev_ack[i])) ack_viol++;
                if (ack0[i] | ack1[i]) begin
                    if (i == 0) glog0.push_back(ack1[i] ? 1 : 0);
                    else        glog1.push_back(ack1[i] ? 1 : 0);
                end
            end
            prev_strobe[i] = mem_memread[i] | mem_memwrite[i];
            prev_ack[i]    = ack0[i] | ack1[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_port(input int i, input int p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        if (p == 0) begin
            req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d; sm0[i] = m;
        end else begin
            req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d; sm1[i] = m;
        end
    endtask

    function automatic logic get_ack(input int i, input int p);
        return (p == 0) ? ack0[i] : ack1[i];
    endfunction

    task automatic wait_ack(input int i, input int p, input int max_cyc, output logic got,
                            output logic [31:0] rd, output logic e, output int n);
        got = 1'b0; rd = 32'h0; e = 1'b0; n = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (get_ack(i, p)) begin
                got = 1'b1; n = c;
                rd = (p == 0) ? rdata0[i] : rdata1[i];
                e  = (p == 0) ? err0[i] : err1[i];
                break;
            end
        end
    endtask

    task automatic do_txn(input int i, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rd, output logic e, output int n);
        logic got;
        @(posedge clk); #1;
        set_port(i, p, 1'b1, w, a, d, m);
        wait_ack(i, p, 40, got, rd, e, n);
        @(posedge clk); #1;
        set_port(i, p, 1'b0, w, a, d, m);
    endtask

    task automatic hold_port(input int i, input int p, input int n);
        int acks = 0;
        @(posedge clk); #1;
        set_port(i, p, 1'b1, 1'b0, 32'h1004, 32'h0, 4'b0100);
        for (int c = 0; c < 200 && acks < n; c++) begin
            @(negedge clk);
            if (get_ack(i, p)) acks++;
        end
        @(posedge clk); #1;
        set_port(i, p, 1'b0, 1'b0, 32'h1004, 32'h0, 4'b0100);
        chk($sformatf("hold_acks_i%0d_p%0d", i, p), acks, n);
    endtask

    logic [31:0] ref_mem [0:2047];
    int last_ack_port = -1;
    int last_ack_cyc = 0;
    int req_start [2];
    logic [1:0] pending = 2'b00;

    task automatic rand_port(input int p, input int n);
        logic w, got, e;
        logic [31:0] a, d, rd;
        int gap, lt, o;
        o = 1 - p;
        for (int t = 0; t < n; t++) begin
            gap = $urandom_range(0, 2);
            @(posedge clk); #1;
            if (gap > 0) begin
                set_port(0, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100);
                repeat (gap) @(posedge clk);
                #1;
            end
            w = 1'($urandom_range(0, 1));
            a = 32'h1100 + ($urandom_range(0, 15) << 2);
            d = $urandom;
            set_port(0, p, 1'b1, w, a, d, 4'b0100);
            req_start[p] = cyc;
            pending[p] = 1'b1;
            wait_ack(0, p, 60, got, rd, e, lt);
            pending[p] = 1'b0;
            chk($sformatf("rand_ack_p%0d", p), got, 1'b1);
            if (got) begin
                chk($sformatf("rand_err_p%0d", p), e, 1'b0);
                chk($sformatf("rand_rdata_p%0d", p), rd, w ? 32'h0 : ref_mem[a[12:2]]);
                if (w) ref_mem[a[12:2]] = merge(ref_mem[a[12:2]], d, 4'b0100, a[1:0]);
                if (last_ack_port >= 0)
                    chk($sformatf("rand_fair_p%0d", p),
                        (last_ack_port == p && pending[o] && req_start[o] <= last_ack_cyc + 1), 1'b0);
                last_ack_port = p;
                last_ack_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        set_port(0, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0100);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sm;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        logic [31:0] rd;
        logic        e, got;
        int          n, s0, drain, a_seen;

        vecs[0] = '{0, 1'b0, 32'h0000_1004, 32'h0,         4'b0100, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 32'h0000_1001, 32'h0000_00A5, 4'b0001, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h0000_1000, 32'h0,         4'b0100, 32'h1122A544};
        vecs[3] = '{1, 1'b1, 32'h0000_2000, 32'h0000_0003, 4'b0100, 32'h0};
        vecs[4] = '{1, 1'b1, 32'h0000_1008, 32'hCAFEF00D,  4'b0100, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h0000_1008, 32'h0,         4'b0100, 32'hCAFEF00D};

        for (int k = 0; k < 2048; k++) ref_mem[k] = 32'h0;
        rst_n = 2'b00; req0 = 2'b00; req1 = 2'b00; we0 = 2'b00; we1 = 2'b00; force_stall = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr0[i] = 32'h0; addr1[i] = 32'h0; wdata0[i] = 32'h0; wdata1[i] = 32'h0;
            sm0[i] = 4'h0; sm1[i] = 4'h0; lat[i] = 2;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ctrl_i%0d", i),
                {26'h0, ack0[i], ack1[i], err0[i], err1[i], mem_memread[i], mem_memwrite[i]}, 32'h0);
            chk($sformatf("rst_mem_addr_i%0d", i), mem_addr[i], 32'h0);
            chk($sformatf("rst_rdata_i%0d", i), rdata0[i] | rdata1[i], 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 2'b11;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            do_txn(0, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sm, rd, e, n);
            chk($sformatf("vec%0d_latency", v), n, 5);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_err", v), e, 1'b0);
            chk($sformatf("vec%0d_mem_addr", v), iss_addr[0], vecs[v].addr);
            chk($sformatf("vec%0d_mem_sm", v), iss_sm[0], vecs[v].sm);
            chk($sformatf("vec%0d_mem_we", v), iss_we[0], vecs[v].we);
        end

        @(posedge clk); #1; rst_n[0] = 1'b0;
        @(posedge clk); #1; rst_n[0] = 1'b1;
        repeat (3) @(posedge clk);
        glog0.delete();
        fork
            hold_port(0, 0, 2);
            hold_port(0, 1, 2);
        join
        chk("rr_grant_count", glog0.size(), 4);
        for (int k = 0; k < 4 && k < glog0.size(); k++)
            chk($sformatf("rr_grant_%0d", k), glog0[k], k % 2);

        glog1.delete();
        fork
            hold_port(1, 0, 4);
            hold_port(1, 1, 1);
        join
        chk("fixed_grant_count", glog1.size(), 5);
        for (int k = 0; k < 5 && k < glog1.size(); k++)
            chk($sformatf("fixed_grant_%0d", k), glog1[k], (k == 4) ? 1 : 0);

        lat[0] = 6;
        @(posedge clk); #1;
        set_port(0, 0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'b0100);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (stall_v[0]) got = 1'b1;
        end
        chk("drain_busy_seen", got, 1'b1);
        @(posedge clk); #1; rst_n[0] = 1'b0;
        @(posedge clk); #1; rst_n[0] = 1'b1;
        set_port(0, 0, 1'b0, 1'b0, 32'h1000, 32'h0, 4'b0100);
        set_port(0, 1, 1'b1, 1'b0, 32'h1004, 32'h0, 4'b0100);
        s0 = strobe_seen; drain = 0; a_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall_v[0]) break;
            drain++;
            if (ack0[0] | ack1[0]) a_seen++;
        end
        chk("drain_stall_after_reset", drain > 0, 1'b1);
        chk("drain_no_strobe", strobe_seen - s0, 0);
        chk("drain_no_ack", a_seen, 0);
        wait_ack(0, 1, 30, got, rd, e, n);
        chk("drain_next_ack", got, 1'b1);
        chk("drain_next_rdata", rd, 32'hDEADBEEF);
        chk("drain_next_err", e, 1'b0);
        @(posedge clk); #1;
        set_port(0, 1, 1'b0, 1'b0, 32'h1004, 32'h0, 4'b0100);
        lat[0] = 2;

        force_stall[0] = 1'b1;
        do_txn(0, 0, 1'b0, 32'h1004, 32'h0, 4'b0100, rd, e, n);
        chk("timeout_latency", n, 18);
        chk("timeout_err", e, 1'b1);
        @(posedge clk); #1;
        set_port(0, 0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'b0100);
        s0 = strobe_seen; a_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0[0] | ack1[0]) a_seen++;
        end
        chk("timeout_drain_no_strobe", strobe_seen - s0, 0);
        chk("timeout_drain_no_ack", a_seen, 0);
        force_stall[0] = 1'b0;
        wait_ack(0, 0, 30, got, rd, e, n);
        chk("timeout_recover_ack", got, 1'b1);
        chk("timeout_recover_rdata", rd, 32'hDEADBEEF);
        chk("timeout_recover_err", e, 1'b0);
        @(posedge clk); #1;
        set_port(0, 0, 1'b0, 1'b0, 32'h1004, 32'h0, 4'b0100);
        repeat (3) @(posedge clk);

        fork
            rand_port(0, 12);
            rand_port(1, 12);
        join

        repeat (4) @(posedge clk);
        chk("strobe_single_cycle", strobe_viol, 0);
        chk("ack_single_cycle", ack_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
